// File: rtl/rf_dump_ctrl_if.sv
// rtl/rf_dump_ctrl_if.sv - register dump beat stream (valid/ready with data and index)
interface rf_dump_ctrl_if;
    logic        dout_valid;
    logic        dout_ready;
    logic [31:0] dout_data;
    logic [4:0]  dout_idx;

    modport master (output dout_valid, output dout_data, output dout_idx, input dout_ready);
    modport slave  (input dout_valid, input dout_data, input dout_idx, output dout_ready);
endinterface

// File: rtl/rf_dump_ctrl.sv
// rtl/rf_dump_ctrl.sv - freezes the CPU on halt PC or timeout, then streams out all 32 registers
module rf_dump_ctrl #(
    parameter logic [31:0] HALT_PC    = 32'h0000_0400,
    parameter int          MAX_CYCLES = 1000,
    parameter int          CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [31:0]          pc_in,
    output logic [4:0]           reg_sel,
    input  logic [31:0]          reg_data,
    output logic                 cpu_hold,
    rf_dump_ctrl_if.master       dout,
    output logic                 dump_done,
    output logic                 timeout
);
    typedef enum logic [1:0] {RUN, SEL, OUT, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cycle_cnt;
    logic [4:0]       idx;
    logic             valid_q;
    logic [31:0]      data_q;
    logic [4:0]       idx_q;

    assign dout.dout_valid = valid_q;
    assign dout.dout_data  = data_q;
    assign dout.dout_idx   = idx_q;

    // reg_sel is loaded on the edge entering SEL, so reg_data has a full stable cycle before capture
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= RUN;
            cycle_cnt <= '0;
            idx       <= '0;
            reg_sel   <= '0;
            cpu_hold  <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            idx_q     <= '0;
            dump_done <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            if (cycle_cnt != '1) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
            case (state)
                RUN: begin
                    if (pc_in == HALT_PC) begin
                        state    <= SEL;
                        cpu_hold <= 1'b1;
                        timeout  <= 1'b0;
                        reg_sel  <= idx;
                    end else if (cycle_cnt == CNT_LAST) begin
                        state    <= SEL;
                        cpu_hold <= 1'b1;
                        timeout  <= 1'b1;
                        reg_sel  <= idx;
                    end
                end
                SEL: begin
                    data_q  <= (idx == 5'd0) ? 32'h0 : reg_data;
                    idx_q   <= idx;
                    valid_q <= 1'b1;
                    state   <= OUT;
                end
                OUT: begin
                    if (dout.dout_ready) begin
                        valid_q <= 1'b0;
                        if (idx == 5'd31) begin
                            state     <= DONE;
                            dump_done <= 1'b1;
                        end else begin
                            idx     <= idx + 5'd1;
                            reg_sel <= idx + 5'd1;
                            state   <= SEL;
                        end
                    end
                end
                DONE: begin
                    valid_q <= 1'b0;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_rf_dump_ctrl.sv
// tb/tb_rf_dump_ctrl.sv - directed self-checking bench for rf_dump_ctrl
module tb_rf_dump_ctrl;
    localparam logic [31:0] HALT = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] pc_in = '0;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic        cpu_hold;
    logic        dump_done;
    logic        timeout;
    logic [31:0] rf [32];

    int n_cmp = 0;
    int n_err = 0;

    rf_dump_ctrl_if dif ();

    rf_dump_ctrl #(.HALT_PC(HALT), .MAX_CYCLES(1000), .CNT_W(16)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .pc_in     (pc_in),
        .reg_sel   (reg_sel),
        .reg_data  (reg_data),
        .cpu_hold  (cpu_hold),
        .dout      (dif),
        .dump_done (dump_done),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    assign reg_data = rf[reg_sel];

    function automatic logic [31:0] expv(input int n);
        return (n == 0) ? 32'h0 : 32'(n) * 32'h1111_1111;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_reg_sel"}, 32'(reg_sel), 0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 0);
        chk({tag, "_valid"}, 32'(dif.dout_valid), 0);
        chk({tag, "_data"}, dif.dout_data, 0);
        chk({tag, "_idx"}, 32'(dif.dout_idx), 0);
        chk({tag, "_done"}, 32'(dump_done), 0);
        chk({tag, "_timeout"}, 32'(timeout), 0);
    endtask

    // Leaves the bench just before edge 0, the first edge counting from cycle_cnt==0
    task automatic do_reset();
        #3;
        rstn = 1'b0;
        pc_in = '0;
        dif.dout_ready = 1'b0;
        #1;
        chk_zero("reset");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Called just after the trigger edge; counts edges until dump_done appears
    task automatic collect(input string tag, input logic exp_to, input int stall_idx, input int exp_len);
        int nxt = 0;
        int stall = 0;
        int cyc = 0;
        dif.dout_ready = 1'b1;
        while (!dump_done && cyc < 400) begin
            if (dif.dout_valid) begin
                if (int'(dif.dout_idx) == stall_idx && stall < 5) begin
                    chk({tag, "_stall_idx"}, 32'(dif.dout_idx), 32'(stall_idx));
                    chk({tag, "_stall_data"}, dif.dout_data, expv(stall_idx));
                    dif.dout_ready = 1'b0;
                    stall++;
                end else begin
                    chk({tag, "_beat_idx"}, 32'(dif.dout_idx), 32'(nxt));
                    chk({tag, "_beat_data"}, dif.dout_data, expv(nxt));
                    dif.dout_ready = 1'b1;
                    nxt++;
                end
            end else begin
                dif.dout_ready = 1'b1;
            end
            tick();
            cyc++;
        end
        chk({tag, "_dump_len"}, 32'(cyc), 32'(exp_len));
        chk({tag, "_beats"}, 32'(nxt), 32);
        chk({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
        chk({tag, "_hold"}, 32'(cpu_hold), 1);
        chk({tag, "_valid_end"}, 32'(dif.dout_valid), 0);
    endtask

    initial begin
        int c;
        for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h1111_1111;
        rf[0] = 32'hDEAD_BEEF;
        dif.dout_ready = 1'b0;

        // Halt-PC trigger at cycle 50
        do_reset();
        repeat (50) tick();
        chk("halt_pre_hold", 32'(cpu_hold), 0);
        pc_in = HALT;
        tick();
        pc_in = '0;
        chk("halt_hold", 32'(cpu_hold), 1);
        chk("halt_timeout", 32'(timeout), 0);
        chk("halt_valid0", 32'(dif.dout_valid), 0);
        chk("halt_reg_sel", 32'(reg_sel), 0);
        collect("halt", 1'b0, -1, 64);

        // Post-done: pc_in and ready toggling has no effect
        for (int i = 0; i < 20; i++) begin
            pc_in = i[0] ? HALT : 32'h0;
            dif.dout_ready = i[1];
            tick();
            chk("post_valid", 32'(dif.dout_valid), 0);
            chk("post_done", 32'(dump_done), 1);
            chk("post_hold", 32'(cpu_hold), 1);
        end

        // Timeout at cycle 999 with backpressure on idx 7
        do_reset();
        repeat (999) tick();
        chk("to_pre_hold", 32'(cpu_hold), 0);
        tick();
        chk("to_hold", 32'(cpu_hold), 1);
        chk("to_timeout", 32'(timeout), 1);
        collect("to", 1'b1, 7, 69);

        // HALT_PC exactly at cycle 999 wins over timeout
        do_reset();
        repeat (999) tick();
        pc_in = HALT;
        tick();
        pc_in = '0;
        chk("sim_hold", 32'(cpu_hold), 1);
        chk("sim_timeout", 32'(timeout), 0);
        collect("sim", 1'b0, -1, 64);

        // Reset during beat 12, then a clean restart from cycle_cnt 0
        do_reset();
        repeat (10) tick();
        pc_in = HALT;
        tick();
        pc_in = '0;
        dif.dout_ready = 1'b1;
        c = 0;
        while (!(dif.dout_valid && dif.dout_idx == 5'd12) && c < 100) begin
            tick();
            c++;
        end
        chk("abort_reach12", 32'(dif.dout_valid && dif.dout_idx == 5'd12), 1);
        #1;
        rstn = 1'b0;
        #1;
        chk_zero("abort");
        dif.dout_ready = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (999) tick();
        chk("restart_pre_hold", 32'(cpu_hold), 0);
        chk("restart_pre_valid", 32'(dif.dout_valid), 0);
        tick();
        chk("restart_hold", 32'(cpu_hold), 1);
        chk("restart_timeout", 32'(timeout), 1);
        collect("restart", 1'b1, -1, 64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
